// File: rtl/restoring_integer_divider_pkg.sv
// Shared integer-arithmetic package: divider FSM states and iteration-counter sizing.
package restoring_integer_divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int unsigned DivDefaultN = 8;
    localparam int unsigned DivCntW     = $clog2(DivDefaultN);

    // Counter must hold N-1; never narrower than one bit.
    function automatic int unsigned div_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational restoring-division subtract step: a - {1'b0, b} built as a + ~b + 1.
module div_sub_stage #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-2:0] b,
    output logic [W-2:0] diff,
    output logic         non_neg
);

    logic [W:0] sum;

    assign sum = {1'b0, a} + {1'b0, 1'b1, ~b} + {{W{1'b0}}, 1'b1};

    // The divider keeps a < 2b, so a set carry already implies a clear result MSB.
    assign non_neg = sum[W] & ~sum[W-1];
    assign diff    = sum[W-2:0];

endmodule

// File: rtl/restoring_integer_divider.sv
// Sequential N-bit restoring divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (one extra sign-correction cycle).
module restoring_integer_divider
    import restoring_integer_divider_pkg::*;
#(
    parameter int unsigned N = DivDefaultN
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CntW = div_cnt_width(N);

    div_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [N-1:0]    quot_q, quot_d, rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic [N:0]      r_shift;
    logic [N-1:0]    t_diff;
    logic            t_non_neg;
    logic            accept;
    logic [N-1:0]    dvd_mag, dvs_mag;
`ifdef SIGNED_DIV_EN
    logic            fix_q, fix_d, qneg_q, qneg_d, rneg_q, rneg_d;
`endif

    assign r_shift = {r_q, q_q[N-1]};

    div_sub_stage #(
        .W(N + 1)
    ) u_div_sub_stage (
        .a      (r_shift),
        .b      (dvs_q),
        .diff   (t_diff),
        .non_neg(t_non_neg)
    );

`ifdef SIGNED_DIV_EN
    assign dvd_mag = dividend[N-1] ? -dividend : dividend;
    assign dvs_mag = divisor[N-1] ? -divisor : divisor;
    assign accept  = start && !fix_q;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign accept  = start;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        fix_d   = fix_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (accept) begin
                    dvs_d   = dvs_mag;
                    q_d     = dvd_mag;
                    r_d     = '0;
                    cnt_d   = CntW'(N - 1);
                    dbz_d   = 1'b0;
                    state_d = RUN;
`ifdef SIGNED_DIV_EN
                    qneg_d  = dividend[N-1] ^ divisor[N-1];
                    rneg_d  = dividend[N-1];
`endif
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
`ifdef SIGNED_DIV_EN
                        fix_d   = 1'b1;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                // First DONE cycle applies the signs; done is only shown afterwards.
                if (fix_q) begin
                    state_d = DONE;
                    fix_d   = 1'b0;
                    if (!dbz_q) begin
                        if (qneg_q) quot_d = -quot_q;
                        if (rneg_q) rem_d = -rem_q;
                    end
                end
`endif
            end
            RUN: begin
                q_d   = {q_q[N-2:0], t_non_neg};
                r_d   = t_non_neg ? t_diff : r_shift[N-1:0];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = q_d;
                    rem_d   = r_d;
`ifdef SIGNED_DIV_EN
                    fix_d   = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            fix_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            fix_q   <= fix_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
`ifdef SIGNED_DIV_EN
    assign done        = (state_q == DONE) && !fix_q;
`else
    assign done        = (state_q == DONE);
`endif
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_integer_divider.sv
// Self-checking bench for restoring_integer_divider (N=8) with a result scoreboard.
module tb_restoring_integer_divider;

    localparam int N = 8;
`ifdef SIGNED_DIV_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif
    localparam int Lat  = N + 1 + Extra;
    localparam int LatZ = 1 + Extra;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    restoring_integer_divider #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa  = $signed(a);
            sb  = $signed(b);
            e.q = N'(sa / sb);
            e.r = N'(sa % sb);
`else
            sa  = int'(a);
            sb  = int'(b);
            e.q = N'(sa / sb);
            e.r = N'(sa % sb);
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Pulse start for one cycle with the operands; returns just after the accepting edge.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd1;
    endtask

    // Counts cycles after the accepting edge until done (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 100);
    endtask

    task automatic test_reset();
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset_n  = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        start    = 1'b1;
        dividend = 8'd50;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_holds: got busy=%b done=%b dbz=%b, want 000",
                     busy, done, div_by_zero);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b q=%h r=%h, want all 0",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   c;
        launch(8'd100, 8'd7);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            checks++;
            if (busy !== (c <= N) || done !== (c == Lat)) begin
                errors++;
                $display("FAIL basic_timing cycle %0d: got busy=%b done=%b, want busy=%b done=%b",
                         c, busy, done, c <= N, c == Lat);
            end
        end while (c < Lat);
        e = exp_q.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            errors++;
            $display("FAIL basic_result: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== e.q) begin
            errors++;
            $display("FAIL done_pulse: got done=%b q=%h, want done=0 q=%h", done, quotient, e.q);
        end
    endtask

    task automatic test_corners();
        logic [N-1:0] a[5];
        logic [N-1:0] b[5];
        exp_t         e;
        int           cyc;
        a = '{8'd255, 8'd5, 8'd0, 8'd254, 8'd7};
        b = '{8'd1, 8'd200, 8'd3, 8'd255, 8'd7};
        for (int i = 0; i < 5; i++) begin
            launch(a[i], b[i]);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != Lat || {quotient, remainder, div_by_zero} !== e) begin
                errors++;
                $display("FAIL corner %0d/%0d: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                         a[i], b[i], cyc, quotient, remainder, div_by_zero, Lat, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        int   cyc;
        launch(8'd42, 8'd0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != LatZ || {quotient, remainder, div_by_zero} !== e) begin
            errors++;
            $display("FAIL div_by_zero: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                     cyc, quotient, remainder, div_by_zero, LatZ, e.q, e.r, e.dbz);
        end
        launch(8'd9, 8'd3);
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b busy=%b, want dbz=0 busy=1", div_by_zero, busy);
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != Lat - 1 || {quotient, remainder, div_by_zero} !== e) begin
            errors++;
            $display("FAIL after_dbz: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                     cyc, quotient, remainder, div_by_zero, Lat - 1, e.q, e.r, e.dbz);
        end
    endtask

    // start stays high throughout; operands only valid around each accepting edge.
    task automatic test_back_to_back();
        logic [N-1:0] a[4];
        logic [N-1:0] b[4];
        exp_t         e;
        int           cyc;
        a = '{8'd200, 8'd99, 8'd17, 8'd255};
        b = '{8'd13, 8'd10, 8'd17, 8'd16};
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a[0];
        divisor  = b[0];
        exp_q.push_back(model(a[0], b[0]));
        @(posedge clk); #1;
        dividend = ~a[0];
        divisor  = 8'd1;
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != Lat || {quotient, remainder, div_by_zero} !== e) begin
                errors++;
                $display("FAIL back_to_back %0d: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                         i, cyc, quotient, remainder, div_by_zero, Lat, e.q, e.r, e.dbz);
            end
            if (i < 3) begin
                dividend = a[i+1];
                divisor  = b[i+1];
                exp_q.push_back(model(a[i+1], b[i+1]));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            dividend = 8'd3;
            divisor  = 8'd1;
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc;
        launch(8'd200, 8'd9);
        e = exp_q.pop_back();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (Lat) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_done_after_abort: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        reset_n = 1'b1;
        launch(8'd123, 8'd10);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != Lat || {quotient, remainder, div_by_zero} !== e) begin
            errors++;
            $display("FAIL after_abort: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                     cyc, quotient, remainder, div_by_zero, Lat, e.q, e.r, e.dbz);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        exp_t         e;
        int           cyc;
        int           want;
        for (int i = 0; i < 10; i++) begin
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(0, (i % 2 == 1) ? 255 : 12));
            want = (b == '0) ? LatZ : Lat;
            launch(a, b);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != want || {quotient, remainder, div_by_zero} !== e) begin
                errors++;
                $display("FAIL random %0d/%0d: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=%b",
                         a, b, cyc, quotient, remainder, div_by_zero, want, e.q, e.r, e.dbz);
            end
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [N-1:0] a[3];
        logic [N-1:0] b[3];
        logic [N-1:0] wq[3];
        logic [N-1:0] wr[3];
        int           cyc;
        a  = '{8'h9C, 8'h80, 8'd100};
        b  = '{8'd7, 8'hFF, 8'hF9};
        wq = '{8'hF2, 8'h80, 8'hF2};
        wr = '{8'hFE, 8'h00, 8'd2};
        for (int i = 0; i < 3; i++) begin
            launch(a[i], b[i]);
            wait_done(cyc);
            void'(exp_q.pop_front());
            checks++;
            if (cyc != Lat || quotient !== wq[i] || remainder !== wr[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL signed %h/%h: got cyc=%0d q=%h r=%h dbz=%b, want cyc=%0d q=%h r=%h dbz=0",
                         a[i], b[i], cyc, quotient, remainder, div_by_zero, Lat, wq[i], wr[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
